pkt_bufid_prefetch: RTL



---
 rtl/pkt_bufid_prefetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pkt_bufid_prefetch.sv
// pkt_bufid_prefetch: per-port prefetch cache of free packet-buffer IDs.
// Fetches bufids one at a time from the free-buffer manager into a small
// register-array FIFO. It presents the head bufid to the port so an ID is ready
// as soon as a frame starts.
// Optional build macro: PKT_BUFID_PREFETCH_STAT_EN enables the 16-bit
// accepted-grant counter on ov_fetch_cnt. Otherwise that output is tied to 0.
module pkt_bufid_prefetch #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_prefetch_enable,
  output logic             o_bufid_req,
  input  logic             i_bufid_grant,
  input  logic [8:0]       iv_bufid,
  input  logic             i_free_empty,
  output logic             o_pkt_bufid_wr,
  output logic [8:0]       ov_pkt_bufid,
  input  logic             i_pkt_bufid_ack,
  output logic [PTR_W:0]   ov_cache_cnt,
  output logic             o_starve_pulse,
  output logic             o_protocol_err_pulse,
  output logic [15:0]      ov_fetch_cnt
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t           state_reg, state_next;
  logic [PTR_W:0]   cnt_reg, cnt_next;
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
  logic [8:0]       mem [DEPTH];
  logic [8:0]       bufid_reg, bufid_next;
  logic             bufid_wr_reg;
  logic             starve_cond, starve_prev_reg, starve_pulse_reg;
  logic             err_pulse_reg;
  logic             push, pop;

  // A grant is only accepted while a request is outstanding; ack only pops a
  // valid head, so the FIFO can neither overflow nor underflow.
  assign push        = (state_reg == REQ) && i_bufid_grant;
  assign pop         = i_pkt_bufid_ack && bufid_wr_reg;
  assign rd_ptr_inc  = rd_ptr_reg + PTR_ONE;
  assign starve_cond = (cnt_reg == '0) && i_prefetch_enable && i_free_empty;

  // Fetch FSM next state: request only when there is room and the manager has stock
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (i_prefetch_enable && (cnt_reg < CNT_FULL) && !i_free_empty)
              state_next = REQ;
      REQ:  if (i_bufid_grant || i_free_empty)
              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy and next head value; a push into an empty (or just-emptied) cache
  // forwards the incoming bufid straight to the head register
  always_comb begin
    cnt_next   = cnt_reg;
    bufid_next = bufid_reg;
    if (push && !pop)
      cnt_next = cnt_reg + CNT_ONE;
    else if (pop && !push)
      cnt_next = cnt_reg - CNT_ONE;
    if (pop) begin
      if (cnt_reg > CNT_ONE)
        bufid_next = mem[rd_ptr_inc];
      else if (push)
        bufid_next = iv_bufid;
    end else if (push && (cnt_reg == '0)) begin
      bufid_next = iv_bufid;
    end
  end

  // Control state, pointers, registered outputs and event pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      bufid_reg        <= '0;
      bufid_wr_reg     <= 1'b0;
      starve_prev_reg  <= 1'b0;
      starve_pulse_reg <= 1'b0;
      err_pulse_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      bufid_reg        <= bufid_next;
      bufid_wr_reg     <= (cnt_next != '0);
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_inc;
      starve_prev_reg  <= starve_cond;
      starve_pulse_reg <= starve_cond && !starve_prev_reg;
      err_pulse_reg    <= (state_reg == IDLE) && i_bufid_grant;
    end
  end

  // Storage entries carry no reset: stale contents are unreachable once the
  // pointers and count are cleared
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi)))
          mem[gi] <= iv_bufid;
      end
    end
  endgenerate

`ifdef PKT_BUFID_PREFETCH_STAT_EN
  logic [15:0] fetch_cnt_reg;

  // Accepted-grant counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      fetch_cnt_reg <= '0;
    else if (push)
      fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
  end

  assign ov_fetch_cnt = fetch_cnt_reg;
`else
  assign ov_fetch_cnt = 16'd0;
`endif

  assign o_bufid_req          = (state_reg == REQ);
  assign o_pkt_bufid_wr       = bufid_wr_reg;
  assign ov_pkt_bufid         = bufid_reg;
  assign ov_cache_cnt         = cnt_reg;
  assign o_starve_pulse       = starve_pulse_reg;
  assign o_protocol_err_pulse = err_pulse_reg;

endmodule
